// File: rtl/dccm_resp.sv
// DCCM memory-side responder: 1R1W word array behind a one-entry posted write buffer,
// with read forwarding, legality checking and a saturating error counter.
module dccm_resp #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dccm_wr_en,
    input  logic [31:0] dccm_wr_addr,
    input  logic [31:0] dccm_wr_data,
    input  logic        dccm_rd_en,
    input  logic [31:0] dccm_rd_addr,
    output logic [31:0] dccm_rd_data,
    output logic        dccm_rd_valid,
    output logic        dccm_err,
    output logic [1:0]  dccm_err_code,
    output logic [15:0] dccm_err_cnt
);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    logic [31:0] mem [DEPTH];

    logic [31:0]   wr_off, rd_off;
    logic          wr_ok, rd_ok;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          wr_take, rd_take, wr_bad, rd_bad;

    logic          wbuf_valid_reg;
    logic [AW-1:0] wbuf_idx_reg;
    logic [31:0]   wbuf_data_reg;

    logic [31:0]   mem_q_reg;
    logic          byp_hit_reg, byp_hit_next;
    logic [31:0]   byp_data_reg, byp_data_next;
    logic          rd_valid_reg;
    logic          err_reg;
    logic [1:0]    err_code_reg;
    logic [15:0]   err_cnt_reg;
    logic [16:0]   err_sum;

    // Subtracting the base first makes below-base addresses wrap high and fail the range test.
    assign wr_off  = dccm_wr_addr - ADDR_BASE;
    assign rd_off  = dccm_rd_addr - ADDR_BASE;
    assign wr_ok   = (wr_off[1:0] == 2'b00) && ({1'b0, wr_off} < SPAN);
    assign rd_ok   = (rd_off[1:0] == 2'b00) && ({1'b0, rd_off} < SPAN);
    assign wr_idx  = wr_off[AW+1:2];
    assign rd_idx  = rd_off[AW+1:2];
    assign wr_take = dccm_wr_en && wr_ok;
    assign rd_take = dccm_rd_en && rd_ok;
    assign wr_bad  = dccm_wr_en && !wr_ok;
    assign rd_bad  = dccm_rd_en && !rd_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            wbuf_valid_reg <= 1'b0;
        end else begin
            wbuf_valid_reg <= wr_take;
        end
        if (wr_take) begin
            wbuf_idx_reg  <= wr_idx;
            wbuf_data_reg <= wr_data_pass(dccm_wr_data);
        end
    end

    function automatic logic [31:0] wr_data_pass(input logic [31:0] d);
        return d;
    endfunction

    // Retirement is suppressed on a reset edge so the buffered write is discarded.
    always_ff @(posedge clk) begin
        if (!rst && wbuf_valid_reg) begin
            mem[wbuf_idx_reg] <= wbuf_data_reg;
        end
        if (rd_take) begin
            mem_q_reg <= mem[rd_idx];
        end
    end

    // Newer data than the array holds: same-cycle write first, then the write buffer.
    always_comb begin
        byp_hit_next  = 1'b0;
        byp_data_next = 32'h0;
        if (!rd_ok) begin
            byp_hit_next = 1'b1;
        end else if (wr_take && (wr_idx == rd_idx)) begin
            byp_hit_next  = 1'b1;
            byp_data_next = dccm_wr_data;
        end else if (wbuf_valid_reg && (wbuf_idx_reg == rd_idx)) begin
            byp_hit_next  = 1'b1;
            byp_data_next = wbuf_data_reg;
        end
    end

    assign err_sum = {1'b0, err_cnt_reg} + 17'(rd_bad) + 17'(wr_bad);

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_hit_reg  <= 1'b1;
            byp_data_reg <= 32'h0;
            rd_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= 2'b00;
            err_cnt_reg  <= 16'h0;
        end else begin
            rd_valid_reg <= dccm_rd_en;
            if (dccm_rd_en) begin
                byp_hit_reg  <= byp_hit_next;
                byp_data_reg <= byp_data_next;
            end
            err_reg      <= rd_bad || wr_bad;
            err_code_reg <= {rd_bad, wr_bad};
            err_cnt_reg  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign dccm_rd_data  = byp_hit_reg ? byp_data_reg : mem_q_reg;
    assign dccm_rd_valid = rd_valid_reg;
    assign dccm_err      = err_reg;
    assign dccm_err_code = err_code_reg;
    assign dccm_err_cnt  = err_cnt_reg;
endmodule

// File: tb/tb_dccm_resp.sv
// Bench for dccm_resp: directed scenarios plus a random phase, all checked against a
// word-array model where every legal write is immediately visible.
module tb_dccm_resp;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid, err;
    logic [1:0]  err_code;
    logic [15:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 0;

    dccm_resp #(.DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .dccm_wr_en(wr_en), .dccm_wr_addr(wr_addr), .dccm_wr_data(wr_data),
        .dccm_rd_en(rd_en), .dccm_rd_addr(rd_addr),
        .dccm_rd_data(rd_data), .dccm_rd_valid(rd_valid),
        .dccm_err(err), .dccm_err_code(err_code), .dccm_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        logic [63:0] a64;
        a64 = 64'(a);
        return (a % 4 == 0) && (a64 >= 64'(BASE)) && (a64 < 64'(BASE) + 64'(4 * DEPTH));
    endfunction

    // Model state: words, a known flag per word, and the one write that a reset can still undo.
    logic [31:0] mdl_mem   [DEPTH];
    bit          mdl_known [DEPTH];
    bit          pend_v = 0;
    int          pend_idx;
    logic [31:0] pend_old;
    bit          pend_oldk;
    bit          exp_valid, exp_err, exp_dk;
    logic [1:0]  exp_code;
    logic [31:0] exp_data;
    int          exp_cnt;

    always @(posedge clk) begin
        if (rst) begin
            if (pend_v) begin
                mdl_mem[pend_idx]   = pend_old;
                mdl_known[pend_idx] = pend_oldk;
            end
            pend_v = 0;
            exp_valid = 0; exp_err = 0; exp_code = 2'b00; exp_cnt = 0;
            exp_data = 32'h0; exp_dk = 1;
        end else begin
            bit wb, rb;
            int wi, ri;
            wb = wr_en && !legal(wr_addr);
            rb = rd_en && !legal(rd_addr);
            pend_v = 0;
            if (wr_en && !wb) begin
                wi = int'((wr_addr - BASE) / 4);
                pend_v = 1; pend_idx = wi;
                pend_old = mdl_mem[wi]; pend_oldk = mdl_known[wi];
                mdl_mem[wi] = wr_data; mdl_known[wi] = 1;
            end
            exp_valid = rd_en;
            if (rd_en) begin
                if (rb) begin
                    exp_data = 32'h0; exp_dk = 1;
                end else begin
                    ri = int'((rd_addr - BASE) / 4);
                    exp_data = mdl_mem[ri]; exp_dk = mdl_known[ri];
                end
            end
            exp_err  = wb || rb;
            exp_code = {rb, wb};
            exp_cnt  = exp_cnt + int'(wb) + int'(rb);
            if (exp_cnt > 65535) exp_cnt = 65535;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_rd_valid", 32'(rd_valid), 32'(exp_valid));
            chk("model_err", 32'(err), 32'(exp_err));
            chk("model_err_code", 32'(err_code), 32'(exp_code));
            chk("model_err_cnt", 32'(err_cnt), 32'(exp_cnt));
            if (exp_dk) chk("model_rd_data", rd_data, exp_data);
        end
    end

    task automatic cyc(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic re, input logic [31:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = 32'h0; wr_data = 32'h0; rd_addr = 32'h0;
        repeat (2) @(negedge clk);
        check_en = 1;
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_err_cnt", 32'(err_cnt), 32'h0);
        rst = 1'b0;

        // Preload words used by later scenarios.
        cyc(1, 32'h0000_0000, 32'h0000_AAAA, 0, 0);
        cyc(1, 32'h0000_0040, 32'h1111_2222, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Write, gap, read through the array.
        cyc(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h0000_0010);
        chk("t1_rd_valid", 32'(rd_valid), 32'h1);
        chk("t1_rd_data", rd_data, 32'hDEAD_BEEF);

        // Same-cycle forwarding, write-buffer forwarding, back-to-back writes.
        cyc(1, 32'h0000_0020, 32'h1234_5678, 1, 32'h0000_0020);
        chk("t2_same_cycle", rd_data, 32'h1234_5678);
        cyc(0, 0, 0, 1, 32'h0000_0020);
        chk("t2_wbuf", rd_data, 32'h1234_5678);
        cyc(1, 32'h0000_0020, 32'h0000_0001, 0, 0);
        cyc(1, 32'h0000_0020, 32'h0000_0002, 0, 0);
        cyc(0, 0, 0, 1, 32'h0000_0020);
        chk("t2_b2b", rd_data, 32'h0000_0002);

        // Illegal read, then illegal write one past the top of the array.
        cyc(0, 0, 0, 1, 32'h0000_0003);
        chk("t3_rd_valid", 32'(rd_valid), 32'h1);
        chk("t3_rd_data", rd_data, 32'h0);
        chk("t3_err", 32'(err), 32'h1);
        chk("t3_err_code", 32'(err_code), 32'h2);
        chk("t3_err_cnt", 32'(err_cnt), 32'h1);
        cyc(1, BASE + 32'(4 * DEPTH), 32'h0BAD_0BAD, 0, 0);
        chk("t3_wr_code", 32'(err_code), 32'h1);
        cyc(0, 0, 0, 1, 32'h0000_0000);
        chk("t3_idx0_intact", rd_data, 32'h0000_AAAA);
        cyc(0, 0, 0, 0, 0);
        chk("t3_err_pulse", 32'(err), 32'h0);

        // Dual errors and counter saturation.
        cyc(1, 32'h0000_0001, 0, 1, 32'h0000_2000);
        chk("t4_code", 32'(err_code), 32'h3);
        chk("t4_cnt", 32'(err_cnt), 32'h4);
        for (int i = 0; i < 32765; i++) cyc(1, 32'h0000_0002, 0, 1, 32'h0000_0005);
        chk("t4_cnt_fffe", 32'(err_cnt), 32'hFFFE);
        cyc(1, 32'h0000_0002, 0, 1, 32'h0000_0005);
        chk("t4_cnt_sat", 32'(err_cnt), 32'hFFFF);
        cyc(0, 0, 0, 1, 32'h0000_0007);
        chk("t4_cnt_hold", 32'(err_cnt), 32'hFFFF);

        // Reset right after a write: read in reset cycle gets no response, write is lost.
        cyc(1, 32'h0000_0040, 32'hA5A5_A5A5, 0, 0);
        rst = 1'b1; rd_en = 1'b1; rd_addr = 32'h0000_0040;
        @(posedge clk);
        @(negedge clk);
        chk("t5_rst_valid", 32'(rd_valid), 32'h0);
        chk("t5_rst_data", rd_data, 32'h0);
        chk("t5_rst_err", 32'(err), 32'h0);
        chk("t5_rst_cnt", 32'(err_cnt), 32'h0);
        rst = 1'b0; rd_en = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h0000_0040);
        chk("t5_old_value", rd_data, 32'h1111_2222);

        // Random concurrent traffic over a small window, with occasional illegal addresses and resets.
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a[2];
            for (int k = 0; k < 2; k++) begin
                int r;
                r = $urandom_range(0, 9);
                a[k] = 32'($urandom_range(0, 15)) << 2;
                if (r == 0) a[k] = a[k] + 32'($urandom_range(1, 3));
                else if (r == 1) a[k] = a[k] + 32'(4 * DEPTH);
            end
            rst = ($urandom_range(0, 499) == 0);
            cyc(1'($urandom_range(0, 1)), a[0], $urandom, 1'($urandom_range(0, 1)), a[1]);
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
